// File: rtl/gcd_job_arbiter_if.sv
// Requester-side and engine-side signal bundle of the shared GCD job arbiter.
// Handshake: a requester holds req (with stable operands) until it sees grant; the
// arbiter keeps grant one-hot from GRANT through RESP and pulses done for one cycle
// with result/error valid; the engine sees core_start/core_in and answers with core_finish.
interface gcd_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] operand_a;
    logic [NUM_REQ*WIDTH-1:0] operand_b;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         result;
    logic                     error;
    logic                     busy;
    logic                     core_clear;
    logic                     core_start;
    logic [WIDTH-1:0]         core_in;
    logic                     core_finish;
    logic [WIDTH-1:0]         core_result;

    modport master (
        output req, operand_a, operand_b, core_finish, core_result,
        input  grant, done, result, error, busy, core_clear, core_start, core_in
    );

    modport slave (
        input  req, operand_a, operand_b, core_finish, core_result,
        output grant, done, result, error, busy, core_clear, core_start, core_in
    );
endinterface

// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter that shares one serially loaded GCD engine among NUM_REQ
// requesters, sequencing clear/start/A/B load, waiting with timeout, returning result.
module gcd_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    gcd_job_arbiter_if.slave  bus,
    output logic [2:0]        dbg_state
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [WIDTH-1:0]   result_q;
    logic               error_q;
    logic               busy_q;
    logic               start_q;
    logic [WIDTH-1:0]   core_in_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    // Scan from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            core_in_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        a_q     <= bus.operand_a[int'(pick_idx)*WIDTH +: WIDTH];
                        b_q     <= bus.operand_b[int'(pick_idx)*WIDTH +: WIDTH];
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // gcd(0,x) = x and gcd(0,0) = 0, so the engine is bypassed.
                    if (a_q == '0 || b_q == '0) begin
                        result_q <= a_q | b_q;
                        error_q  <= 1'b0;
                        done_q   <= grant_q;
                        state_q  <= S_RESP;
                    end else begin
                        start_q   <= 1'b1;
                        core_in_q <= a_q;
                        state_q   <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    start_q   <= 1'b0;
                    core_in_q <= b_q;
                    state_q   <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.core_finish) begin
                        result_q <= bus.core_result;
                        error_q  <= 1'b0;
                        done_q   <= grant_q;
                        state_q  <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                        done_q   <= grant_q;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr    <= owner_q;
                    grant_q   <= '0;
                    done_q    <= '0;
                    core_in_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.error      = error_q;
    assign bus.busy       = busy_q;
    assign bus.core_start = start_q;
    assign bus.core_in    = core_in_q;
    // Engine must be re-initialised both on a new job and while the system is in reset.
    assign bus.core_clear = reset | (state_q == S_GRANT);
    assign dbg_state      = state_q;

    a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));
    a_done_owner:   assert property (@(posedge clock) disable iff (reset) (done_q & ~grant_q) == '0);
endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter: drives requesters and a scripted engine,
// checks every output against hand-computed values.
module tb_gcd_job_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clock;
    logic       reset;
    logic [2:0] dbg_state;
    int         n_total;
    int         n_bad;

    gcd_job_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    gcd_job_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs one job from its IDLE request cycle through the IDLE cycle after done.
    task automatic do_job(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input int w, input logic fin, input logic [7:0] core_res,
                          input logic [7:0] exp_res, input logic exp_err, input logic keep);
        logic [3:0] exp_g;
        exp_g = 4'b0001 << idx;
        bus.req[idx] = 1'b1;
        bus.operand_a[idx*WIDTH +: WIDTH] = a;
        bus.operand_b[idx*WIDTH +: WIDTH] = b;
        step();
        chk("grant", bus.grant, exp_g);
        chk("clear_in_grant", bus.core_clear, 1);
        chk("busy_in_grant", bus.busy, 1);
        chk("start_in_grant", bus.core_start, 0);
        if (!keep) bus.req[idx] = 1'b0;
        if (a != 0 && b != 0) begin
            step();
            chk("start_in_load_a", bus.core_start, 1);
            chk("core_in_a", bus.core_in, a);
            step();
            chk("start_in_load_b", bus.core_start, 0);
            chk("core_in_b", bus.core_in, b);
            for (int i = 1; i <= w; i++) begin
                step();
                chk("done_in_wait", bus.done, 0);
                chk("core_in_wait", bus.core_in, b);
                if (fin && i == w) begin
                    bus.core_finish = 1'b1;
                    bus.core_result = core_res;
                end
            end
        end
        step();
        bus.core_finish = 1'b0;
        chk("done", bus.done, exp_g);
        chk("result", bus.result, exp_res);
        chk("error", bus.error, exp_err);
        chk("grant_in_resp", bus.grant, exp_g);
        if (a == 0 || b == 0) chk("no_start_zero", bus.core_start, 0);
        step();
        chk("done_clear", bus.done, 0);
        chk("grant_clear", bus.grant, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        bus.req = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.core_finish = 1'b0;
        bus.core_result = '0;
        #2;
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.core_start, 0);
        chk("rst_core_in", bus.core_in, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_clear", bus.core_clear, 1);
        chk("rst_state", dbg_state, 0);
        step();
        reset = 1'b0;
        step();
        chk("clear_idle", bus.core_clear, 0);

        // gcd(48,18)=6, engine finishes in 5th WAIT cycle: done 9 cycles after req
        do_job(1, 8'd48, 8'd18, 5, 1'b1, 8'd6, 8'd6, 1'b0, 1'b0);

        // simultaneous req0/req2 after reset: 0 first, then 2
        do_reset();
        bus.req[2] = 1'b1;
        bus.operand_a[2*WIDTH +: WIDTH] = 8'd27;
        bus.operand_b[2*WIDTH +: WIDTH] = 8'd9;
        do_job(0, 8'd10, 8'd4, 2, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        do_job(2, 8'd27, 8'd9, 3, 1'b1, 8'd9, 8'd9, 1'b0, 1'b0);

        // zero-operand bypass
        do_job(3, 8'd0, 8'd35, 0, 1'b0, 8'd0, 8'd35, 1'b0, 1'b0);
        do_job(3, 8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // req1 and req3 held continuously: 1,3,1,3,1,3
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            do_job(1, 8'd15, 8'd10, 2, 1'b1, 8'd5, 8'd5, 1'b0, 1'b1);
            do_job(3, 8'd21, 8'd14, 1, 1'b1, 8'd7, 8'd7, 1'b0, 1'b1);
        end
        bus.req[1] = 1'b0;
        bus.req[3] = 1'b0;
        step();
        chk("idle_after_hold", bus.grant, 0);

        // engine never finishes: exactly TIMEOUT WAIT cycles then error
        do_job(0, 8'd12, 8'd8, TIMEOUT, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

        // reset pulsed during WAIT
        bus.req[2] = 1'b1;
        bus.operand_a[2*WIDTH +: WIDTH] = 8'd20;
        bus.operand_b[2*WIDTH +: WIDTH] = 8'd5;
        step();
        chk("mid_grant", bus.grant, 4'b0100);
        step();
        step();
        step();
        chk("mid_in_wait", bus.core_in, 8'd5);
        reset = 1'b1;
        #1;
        chk("async_grant", bus.grant, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_core_in", bus.core_in, 0);
        chk("async_done", bus.done, 0);
        chk("async_clear", bus.core_clear, 1);
        chk("async_state", dbg_state, 0);
        step();
        chk("rst_hold_done", bus.done, 0);
        reset = 1'b0;
        // req2 still pending; rr pointer back at NUM_REQ-1 so req0 wins
        do_job(0, 8'd9, 8'd6, 1, 1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        do_job(2, 8'd0, 8'd9, 0, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
